// File: rtl/fetch_unit.sv
// Instruction fetch stage: issues word reads for generated PCs and
// buffers returned instructions in a 2-entry FIFO toward decode.
module fetch_unit #(
    parameter int PCLEN  = 10,
    parameter int IWIDTH = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [PCLEN-1:0]  pc_in,
    input  logic              pc_valid,
    output logic              pc_take,
    output logic              mem_req,
    output logic [PCLEN-1:0]  mem_addr,
    input  logic              mem_ack,
    input  logic [IWIDTH-1:0] mem_rdata,
    input  logic              flush,
    output logic              if_valid,
    input  logic              if_ready,
    output logic [IWIDTH-1:0] if_instr,
    output logic [PCLEN-1:0]  if_pc,
    output logic              busy
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        DROP = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic               req_q, req_d;
    logic [PCLEN-1:0]   addr_q, addr_d;
    logic [PCLEN-1:0]   pc_q, pc_d;

    logic [IWIDTH-1:0]  qi_q [2];
    logic [PCLEN-1:0]   qp_q [2];
    logic               wptr_q, rptr_q;
    logic [1:0]         cnt_q;

    logic               pop;
    logic               push;
    logic               launch;
    logic [1:0]         cnt_pop;

    // Handshake events seen by the queue this cycle
    always_comb begin
        pop     = (cnt_q != 2'd0) && if_ready;
        push    = (state_q == REQ) && mem_ack && !flush;
        cnt_pop = cnt_q - {1'b0, pop};
    end

    // Next-state logic: launch, back-to-back relaunch, flush draining
    always_comb begin
        state_d = state_q;
        req_d   = req_q;
        addr_d  = addr_q;
        pc_d    = pc_q;
        launch  = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (pc_valid && !flush && cnt_pop <= 2'd1) begin
                    launch = 1'b1;
                end
            end
            REQ: begin
                if (flush) begin
                    if (mem_ack) begin
                        state_d = IDLE;
                        req_d   = 1'b0;
                    end else begin
                        state_d = DROP;
                    end
                end else if (mem_ack) begin
                    // post-push count is cnt_pop + 1, so relaunch needs cnt_pop == 0
                    if (pc_valid && cnt_pop == 2'd0) begin
                        launch = 1'b1;
                    end else begin
                        state_d = IDLE;
                        req_d   = 1'b0;
                    end
                end
            end
            DROP: begin
                if (mem_ack) begin
                    state_d = IDLE;
                    req_d   = 1'b0;
                end
            end
            default: begin
                state_d = IDLE;
                req_d   = 1'b0;
            end
        endcase
        if (launch) begin
            state_d = REQ;
            req_d   = 1'b1;
            addr_d  = {pc_in[PCLEN-1:2], 2'b00};
            pc_d    = pc_in;
        end
    end

    // Request state registers
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            req_q   <= 1'b0;
            addr_q  <= '0;
            pc_q    <= '0;
        end else begin
            state_q <= state_d;
            req_q   <= req_d;
            addr_q  <= addr_d;
            pc_q    <= pc_d;
        end
    end

    // Two-entry instruction FIFO; flush empties it and drops any push
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_q  <= 2'd0;
            wptr_q <= 1'b0;
            rptr_q <= 1'b0;
        end else if (flush) begin
            cnt_q  <= 2'd0;
            wptr_q <= 1'b0;
            rptr_q <= 1'b0;
        end else begin
            if (push) begin
                qi_q[wptr_q] <= mem_rdata;
                qp_q[wptr_q] <= pc_q;
                wptr_q       <= ~wptr_q;
            end
            if (pop) begin
                rptr_q <= ~rptr_q;
            end
            cnt_q <= cnt_q + {1'b0, push} - {1'b0, pop};
        end
    end

    // The launch rule reserves a slot, so a push never meets a full queue
    always_ff @(posedge clk) begin
        if (rst_n) begin
            assert (!(push && cnt_q == 2'd2));
        end
    end

    // Output views of state and queue head
    always_comb begin
        pc_take  = launch && rst_n;
        mem_req  = req_q;
        mem_addr = addr_q;
        busy     = (state_q != IDLE);
        if_valid = (cnt_q != 2'd0);
        if_instr = if_valid ? qi_q[rptr_q] : '0;
        if_pc    = if_valid ? qp_q[rptr_q] : '0;
    end

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: PC feeder, memory model and FIFO scoreboard
// comparing every decode-side pop against the fetched PC order.
module tb_fetch_unit;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [9:0]  pc_in;
    logic        pc_valid;
    logic        pc_take;
    logic        mem_req;
    logic [9:0]  mem_addr;
    logic        mem_ack;
    logic [31:0] mem_rdata;
    logic        flush;
    logic        if_valid;
    logic        if_ready;
    logic [31:0] if_instr;
    logic [9:0]  if_pc;
    logic        busy;

    logic ack_force;
    logic ack_en;
    logic ovr;

    typedef struct {
        logic [9:0]  pc;
        logic [31:0] ins;
    } ent_t;

    ent_t       sb [$];
    logic [9:0] pcs [$];
    logic       took;
    logic       pend;
    logic [9:0] pend_addr;
    int         npops;
    int         total;
    int         bad;

    always #5 clk = ~clk;

    function automatic logic [31:0] f(input logic [9:0] a);
        return 32'hA0 + 32'(a[9:2]);
    endfunction

    assign mem_ack   = ack_force | (ack_en & mem_req);
    assign mem_rdata = ovr ? 32'h0000_DEAD : f(mem_addr);

    fetch_unit #(.PCLEN(10), .IWIDTH(32)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .pc_in    (pc_in),
        .pc_valid (pc_valid),
        .pc_take  (pc_take),
        .mem_req  (mem_req),
        .mem_addr (mem_addr),
        .mem_ack  (mem_ack),
        .mem_rdata(mem_rdata),
        .flush    (flush),
        .if_valid (if_valid),
        .if_ready (if_ready),
        .if_instr (if_instr),
        .if_pc    (if_pc),
        .busy     (busy)
    );

    task automatic chk(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic refresh();
        pc_valid = (pcs.size() != 0);
        pc_in    = pc_valid ? pcs[0] : 10'h0;
    endtask

    task automatic feed(input logic [9:0] p);
        pcs.push_back(p);
        refresh();
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        if (took && pcs.size() != 0) void'(pcs.pop_front());
        refresh();
    endtask

    // Monitor: scoreboard push on pc_take, compare on pop, clear on flush
    always @(negedge clk) begin
        if (!rst_n) begin
            sb.delete();
            took = 1'b0;
            pend = 1'b0;
        end else begin
            if (pend) begin
                chk("req_after_take", 32'(mem_req), 32'd1);
                chk("mem_addr", 32'(mem_addr), 32'(pend_addr));
            end
            pend = 1'b0;
            if (flush) begin
                sb.delete();
            end else if (if_valid && if_ready) begin
                chk("pop_expected", 32'(sb.size() != 0), 32'd1);
                if (sb.size() != 0) begin
                    ent_t e;
                    e = sb.pop_front();
                    chk("if_pc", 32'(if_pc), 32'(e.pc));
                    chk("if_instr", if_instr, e.ins);
                end
                npops++;
            end
            took = pc_take;
            if (pc_take) begin
                ent_t n;
                n.pc  = pc_in;
                n.ins = f(pc_in);
                sb.push_back(n);
                pend      = 1'b1;
                pend_addr = {pc_in[9:2], 2'b00};
            end
        end
    end

    initial begin
        total = 0;
        bad = 0;
        npops = 0;
        took = 1'b0;
        pend = 1'b0;
        rst_n = 1'b0;
        flush = 1'b0;
        if_ready = 1'b0;
        ack_force = 1'b1;
        ack_en = 1'b0;
        ovr = 1'b0;
        feed(10'h000);

        // reset hold with pc_valid and a stray ack
        repeat (3) step();
        @(negedge clk);
        chk("rst_mem_req", 32'(mem_req), 32'd0);
        chk("rst_mem_addr", 32'(mem_addr), 32'd0);
        chk("rst_pc_take", 32'(pc_take), 32'd0);
        chk("rst_if_valid", 32'(if_valid), 32'd0);
        chk("rst_if_instr", if_instr, 32'd0);
        chk("rst_if_pc", 32'(if_pc), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);

        // release and stream three words
        step();
        rst_n = 1'b1;
        ack_force = 1'b0;
        ack_en = 1'b1;
        if_ready = 1'b1;
        feed(10'h004);
        feed(10'h008);
        @(negedge clk);
        chk("take_after_rst", 32'(pc_take), 32'd1);
        chk("take_pc", 32'(pc_in), 32'h000);
        repeat (7) step();
        @(negedge clk);
        chk("stream_pops", 32'(npops), 32'd3);
        chk("stream_sb", 32'(sb.size()), 32'd0);

        // backpressure
        step();
        if_ready = 1'b0;
        feed(10'h020);
        feed(10'h024);
        feed(10'h028);
        feed(10'h02C);
        repeat (8) step();
        @(negedge clk);
        chk("bp_valid", 32'(if_valid), 32'd1);
        chk("bp_req", 32'(mem_req), 32'd0);
        chk("bp_take", 32'(pc_take), 32'd0);
        chk("bp_busy", 32'(busy), 32'd0);
        chk("bp_taken", 32'(pcs.size()), 32'd2);
        chk("bp_head", 32'(if_pc), 32'h020);
        step();
        if_ready = 1'b1;
        repeat (10) step();
        @(negedge clk);
        chk("bp_pcs", 32'(pcs.size()), 32'd0);
        chk("bp_sb", 32'(sb.size()), 32'd0);
        chk("bp_pops", 32'(npops), 32'd7);

        // flush with fetch in flight, late ack
        step();
        ack_en = 1'b0;
        feed(10'h010);
        step();
        @(negedge clk);
        chk("fl_req", 32'(mem_req), 32'd1);
        chk("fl_addr", 32'(mem_addr), 32'h010);
        step();
        flush = 1'b1;
        ovr = 1'b1;
        pcs.delete();
        refresh();
        @(negedge clk);
        chk("fl_take", 32'(pc_take), 32'd0);
        step();
        flush = 1'b0;
        @(negedge clk);
        chk("drop_busy", 32'(busy), 32'd1);
        chk("drop_req", 32'(mem_req), 32'd1);
        chk("drop_valid", 32'(if_valid), 32'd0);
        step();
        step();
        ack_en = 1'b1;
        feed(10'h3F0);
        @(negedge clk);
        chk("drop_notake", 32'(pc_take), 32'd0);
        pcs.delete();
        step();
        refresh();
        ovr = 1'b0;
        @(negedge clk);
        chk("drop_idle", 32'(busy), 32'd0);
        chk("drop_req0", 32'(mem_req), 32'd0);
        chk("drop_valid2", 32'(if_valid), 32'd0);
        feed(10'h100);
        repeat (5) step();
        @(negedge clk);
        chk("fl_pops", 32'(npops), 32'd8);
        chk("fl_sb", 32'(sb.size()), 32'd0);

        // flush coinciding with ack and pop
        step();
        if_ready = 1'b0;
        feed(10'h030);
        feed(10'h034);
        step();
        step();
        flush = 1'b1;
        if_ready = 1'b1;
        pcs.delete();
        refresh();
        @(negedge clk);
        chk("fa_take", 32'(pc_take), 32'd0);
        chk("fa_valid_pre", 32'(if_valid), 32'd1);
        chk("fa_ack", 32'(mem_ack), 32'd1);
        step();
        flush = 1'b0;
        @(negedge clk);
        chk("fa_valid", 32'(if_valid), 32'd0);
        chk("fa_busy", 32'(busy), 32'd0);
        chk("fa_req", 32'(mem_req), 32'd0);
        chk("fa_pops", 32'(npops), 32'd8);

        // misaligned pc
        step();
        feed(10'h00B);
        @(negedge clk);
        chk("mis_take", 32'(pc_take), 32'd1);
        step();
        @(negedge clk);
        chk("mis_addr", 32'(mem_addr), 32'h008);
        step();
        @(negedge clk);
        chk("mis_pc", 32'(if_pc), 32'h00B);
        chk("mis_instr", if_instr, 32'hA2);
        repeat (3) step();
        @(negedge clk);
        chk("mis_pops", 32'(npops), 32'd9);
        chk("end_sb", 32'(sb.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
- Instruction fetch stage directly downstream of the PC generator (`newPc`).
- Takes the generated program counter and issues word reads to instruction memory over a req/ack handshake.
- Buffers returned instructions with their PC in a 2-entry queue and hands them to decode over a valid/ready handshake.
- A flush from branch resolution discards queued instructions and any in-flight fetch.

Parameters:
- PCLEN, 10, PC/byte-address width; must match the PC generator.
- IWIDTH, 32, instruction word width.

Ports:
- clk  in  1  clock; all state updates on posedge.
- rst_n  in  1  synchronous active-low reset.
- pc_in  in  PCLEN  next fetch address from the PC generator.
- pc_valid  in  1  pc_in is valid and may be fetched.
- pc_take  out  1  one-cycle pulse: pc_in captured this cycle; PC generator may advance.
- mem_req  out  1  memory read request (registered).
- mem_addr  out  PCLEN  word-aligned read address (registered).
- mem_ack  in  1  read complete this cycle; mem_rdata valid.
- mem_rdata  in  IWIDTH  instruction data.
- flush  in  1  discard all queued and in-flight fetches.
- if_valid  out  1  queue head valid.
- if_ready  in  1  decode accepts head.
- if_instr  out  IWIDTH  head instruction.
- if_pc  out  PCLEN  head PC.
- busy  out  1  request outstanding (state != IDLE).

Behaviour:
- Reset (rst_n=0 at posedge): state IDLE; queue count 0, read/write pointers 0.
  - All outputs 0: mem_req, mem_addr, pc_take, if_valid, if_instr, if_pc, busy.
  - Reset mid-transaction abandons it; a later stray mem_ack in IDLE is ignored.
- Address rule: mem_addr = {pc_in[PCLEN-1:2], 2'b00}; pc_in[1:0] is ignored. The queued PC is the full pc_in.
- Transaction rule: a transaction completes at a posedge where mem_req=1 and mem_ack=1. mem_addr is stable while mem_req=1.
- Pop rule: occurs at a posedge with if_valid=1 and if_ready=1. Queue outputs if_instr/if_pc always show the head entry (zero when empty).
- IDLE:
  - Launch when pc_valid=1, flush=0 and count<=1 (count includes a same-cycle pop).
  - On launch: pc_take=1 (combinational) that cycle; next cycle mem_req=1, mem_addr set from pc_in; go to REQ.
- REQ, on mem_ack without flush:
  - Push {pc, mem_rdata}.
  - If pc_valid=1 and the post-push/pop count <=1: relaunch back-to-back (pc_take=1, new mem_addr, stay REQ, mem_req stays 1).
  - Otherwise mem_req=0 next cycle and go to IDLE.
  - Max throughput is 1 instruction per cycle with a single-cycle-ack memory.
- REQ, flush=1 without mem_ack: go to DROP; keep mem_req=1 with the same mem_addr.
- REQ, flush=1 with mem_ack in the same cycle: data discarded, mem_req=0, go to IDLE.
- DROP: wait for mem_ack, discard data, mem_req=0, go to IDLE. No launch and pc_take=0 while in DROP.
- Flush in any state:
  - Queue count goes to 0 next cycle; if_valid=0 next cycle.
  - A same-cycle pop is ignored (flush wins); a same-cycle push is discarded.
  - pc_take=0 during a flush cycle.
- Queue never overflows: the launch condition reserves a slot for the in-flight fetch. The design must include an assertion that push with count==2 never occurs.
- Queue order is strict FIFO; the count wraps nowhere; pointers wrap modulo 2.
- busy = (state != IDLE).

Test Plan:
- Reset hold: rst_n=0 for 3 cycles with pc_valid=1, mem_ack=1 → all outputs 0, no pc_take; release → pc_take next cycle with pc_in=0x000, then mem_req=1, mem_addr=0x000.
- Streaming: pc_in 0x000,0x004,0x008, mem_ack every cycle, if_ready=1 → if_pc 0x000,0x004,0x008 on consecutive cycles; if_instr matches mem_rdata 0xA0,0xA1,0xA2.
- Backpressure: if_ready=0 → at most 2 entries queued, then mem_req=0 and pc_take=0. Set if_ready=1 → entries drain in order and fetching resumes.
- Flush in flight: mem_addr=0x010 outstanding, flush=1, ack 3 cycles later with 0xDEAD → if_valid stays 0, 0xDEAD never appears, state returns to IDLE, next fetch 0x100 delivered.
- Flush+ack same cycle, and flush+pop same cycle → data discarded, queue empty next cycle, no pc_take that cycle.
- Misaligned pc_in=0x00B → mem_addr=0x008, if_pc=0x00B.
